uart_bdgen_frac: RTL and testbench

Parametrised baud generator for the UART, successor to the integer-only tick generator. Produces the TX bit-rate pulse from a fractional divisor (integer + FRAC_W-bit fraction, accumulator dithered) and a separate RX oversampling timebase with per-tick, mid-bit and end-of-bit pulses. Divisors can be reloaded at runtime through shadow registers that commit only on period boundaries. Sits between the UART register file and the `uart_tx` / `uart_rx` FSMs.

---
 rtl/uart_bdgen_frac.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_bdgen_frac.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_bdgen_frac.sv
// Purpose: UART baud generator; fractional TX bit pulse plus RX oversample/mid/end-of-bit pulses, shadowed runtime divisors.
// Latency: all pulses are registered, first pls_tx after len enabled edges; cfg commits on period boundaries or while disabled.
// Backpressure: none; tx_en/rx_en stall and clear their timebase. Optional fractional path under `define UART_BDGEN_FRAC_EN.
module uart_bdgen_frac #(
  parameter int DIV_W      = 16,
  parameter int FRAC_W     = 4,
  parameter int OVS_W      = 5,
  parameter int TX_DIV_RST = 868,
  parameter int RX_DIV_RST = 54,
  parameter int OVS_RST    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              rx_en,
  input  logic              rx_sync,
  input  logic              cfg_ld,
  input  logic [DIV_W-1:0]  cfg_tx_div,
  input  logic [FRAC_W-1:0] cfg_tx_frac,
  input  logic [DIV_W-1:0]  cfg_rx_div,
  input  logic [OVS_W-1:0]  cfg_rx_ovs,
  output logic              cfg_pend,
  output logic              pls_tx,
  output logic              pls_rx_ovs,
  output logic              pls_rx_mid,
  output logic              pls_rx_bit
);

  // live configuration
  logic [DIV_W-1:0] tx_div_q, tx_div_d;
  logic [DIV_W-1:0] rx_div_q, rx_div_d;
  logic [OVS_W-1:0] rx_ovs_q, rx_ovs_d;
  // shadow configuration
  logic [DIV_W-1:0] sh_tx_div_q, sh_tx_div_d;
  logic [DIV_W-1:0] sh_rx_div_q, sh_rx_div_d;
  logic [OVS_W-1:0] sh_rx_ovs_q, sh_rx_ovs_d;
  logic             tx_pend_q, tx_pend_d;
  logic             rx_pend_q, rx_pend_d;
  // timebase state
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [OVS_W-1:0] ovs_cnt_q, ovs_cnt_d;
  logic             pls_tx_q, pls_tx_d;
  logic             pls_rx_ovs_q, pls_rx_ovs_d;
  logic             pls_rx_mid_q, pls_rx_mid_d;
  logic             pls_rx_bit_q, pls_rx_bit_d;

`ifdef UART_BDGEN_FRAC_EN
  logic [FRAC_W-1:0] tx_frac_q, tx_frac_d;
  logic [FRAC_W-1:0] sh_tx_frac_q, sh_tx_frac_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [FRAC_W:0]   acc_sum;
`else
  // fraction input has no effect in the integer-only build
  logic unused_frac;
  assign unused_frac = ^cfg_tx_frac;
`endif

  // clamped shadow values presented at commit
  logic [DIV_W-1:0] sh_tx_div_cl, sh_rx_div_cl;
  logic [OVS_W-1:0] sh_rx_ovs_cl;
  logic [DIV_W:0]   tx_len;
  logic             tx_bnd, tx_commit;
  logic             rx_tick, rx_mid, rx_last, rx_commit;

  // decode boundaries, clamps and commit conditions
  always_comb begin
    sh_tx_div_cl = (sh_tx_div_q < DIV_W'(2)) ? DIV_W'(2) : sh_tx_div_q;
    sh_rx_div_cl = (sh_rx_div_q == '0)       ? DIV_W'(1) : sh_rx_div_q;
    sh_rx_ovs_cl = (sh_rx_ovs_q < OVS_W'(2)) ? OVS_W'(2) : sh_rx_ovs_q;
`ifdef UART_BDGEN_FRAC_EN
    tx_len  = {1'b0, tx_div_q} + {{DIV_W{1'b0}}, ext_q};
    acc_sum = {1'b0, acc_q} + {1'b0, tx_frac_q};
`else
    tx_len  = {1'b0, tx_div_q};
`endif
    tx_bnd    = ({1'b0, tx_cnt_q} == (tx_len - (DIV_W+1)'(1)));
    tx_commit = ~tx_en | (tx_bnd & tx_pend_q);
    rx_tick   = (rx_cnt_q == (rx_div_q - DIV_W'(1)));
    rx_mid    = (ovs_cnt_q == (rx_ovs_q >> 1));
    rx_last   = (ovs_cnt_q == (rx_ovs_q - OVS_W'(1)));
    rx_commit = ~rx_en | (rx_sync & rx_pend_q);
  end

  // shadow capture and pending flags; a coincident cfg_ld keeps pend set
  always_comb begin
    sh_tx_div_d = sh_tx_div_q;
    sh_rx_div_d = sh_rx_div_q;
    sh_rx_ovs_d = sh_rx_ovs_q;
`ifdef UART_BDGEN_FRAC_EN
    sh_tx_frac_d = sh_tx_frac_q;
`endif
    tx_pend_d = tx_pend_q;
    rx_pend_d = rx_pend_q;
    if (tx_commit) tx_pend_d = 1'b0;
    if (rx_commit) rx_pend_d = 1'b0;
    if (cfg_ld) begin
      sh_tx_div_d = cfg_tx_div;
      sh_rx_div_d = cfg_rx_div;
      sh_rx_ovs_d = cfg_rx_ovs;
`ifdef UART_BDGEN_FRAC_EN
      sh_tx_frac_d = cfg_tx_frac;
`endif
      tx_pend_d = 1'b1;
      rx_pend_d = 1'b1;
    end
  end

  // TX bit timebase with dithered period and boundary commit
  always_comb begin
    tx_div_d = tx_div_q;
    tx_cnt_d = tx_cnt_q;
    pls_tx_d = 1'b0;
`ifdef UART_BDGEN_FRAC_EN
    tx_frac_d = tx_frac_q;
    acc_d     = acc_q;
    ext_d     = ext_q;
`endif
    if (!tx_en) begin
      tx_cnt_d = '0;
    end else if (tx_bnd) begin
      tx_cnt_d = '0;
      pls_tx_d = 1'b1;
`ifdef UART_BDGEN_FRAC_EN
      {ext_d, acc_d} = acc_sum;
`endif
    end else begin
      tx_cnt_d = tx_cnt_q + DIV_W'(1);
    end
    if (tx_commit) begin
      tx_div_d = sh_tx_div_cl;
`ifdef UART_BDGEN_FRAC_EN
      tx_frac_d = sh_tx_frac_q;
      acc_d     = '0;
      ext_d     = 1'b0;
`endif
    end
  end

  // RX oversample timebase; rx_sync restarts phase and beats a coincident wrap
  always_comb begin
    rx_div_d     = rx_div_q;
    rx_ovs_d     = rx_ovs_q;
    rx_cnt_d     = rx_cnt_q;
    ovs_cnt_d    = ovs_cnt_q;
    pls_rx_ovs_d = 1'b0;
    pls_rx_mid_d = 1'b0;
    pls_rx_bit_d = 1'b0;
    if (!rx_en || rx_sync) begin
      rx_cnt_d  = '0;
      ovs_cnt_d = '0;
    end else if (rx_tick) begin
      rx_cnt_d     = '0;
      pls_rx_ovs_d = 1'b1;
      pls_rx_mid_d = rx_mid;
      pls_rx_bit_d = rx_last;
      ovs_cnt_d    = rx_last ? '0 : ovs_cnt_q + OVS_W'(1);
    end else begin
      rx_cnt_d = rx_cnt_q + DIV_W'(1);
    end
    if (rx_commit) begin
      rx_div_d = sh_rx_div_cl;
      rx_ovs_d = sh_rx_ovs_cl;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_div_q     <= DIV_W'(TX_DIV_RST);
      rx_div_q     <= DIV_W'(RX_DIV_RST);
      rx_ovs_q     <= OVS_W'(OVS_RST);
      sh_tx_div_q  <= DIV_W'(TX_DIV_RST);
      sh_rx_div_q  <= DIV_W'(RX_DIV_RST);
      sh_rx_ovs_q  <= OVS_W'(OVS_RST);
      tx_pend_q    <= 1'b0;
      rx_pend_q    <= 1'b0;
      tx_cnt_q     <= '0;
      rx_cnt_q     <= '0;
      ovs_cnt_q    <= '0;
      pls_tx_q     <= 1'b0;
      pls_rx_ovs_q <= 1'b0;
      pls_rx_mid_q <= 1'b0;
      pls_rx_bit_q <= 1'b0;
`ifdef UART_BDGEN_FRAC_EN
      tx_frac_q    <= '0;
      sh_tx_frac_q <= '0;
      acc_q        <= '0;
      ext_q        <= 1'b0;
`endif
    end else begin
      tx_div_q     <= tx_div_d;
      rx_div_q     <= rx_div_d;
      rx_ovs_q     <= rx_ovs_d;
      sh_tx_div_q  <= sh_tx_div_d;
      sh_rx_div_q  <= sh_rx_div_d;
      sh_rx_ovs_q  <= sh_rx_ovs_d;
      tx_pend_q    <= tx_pend_d;
      rx_pend_q    <= rx_pend_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_cnt_q     <= rx_cnt_d;
      ovs_cnt_q    <= ovs_cnt_d;
      pls_tx_q     <= pls_tx_d;
      pls_rx_ovs_q <= pls_rx_ovs_d;
      pls_rx_mid_q <= pls_rx_mid_d;
      pls_rx_bit_q <= pls_rx_bit_d;
`ifdef UART_BDGEN_FRAC_EN
      tx_frac_q    <= tx_frac_d;
      sh_tx_frac_q <= sh_tx_frac_d;
      acc_q        <= acc_d;
      ext_q        <= ext_d;
`endif
    end
  end

  assign cfg_pend   = tx_pend_q | rx_pend_q;
  assign pls_tx     = pls_tx_q;
  assign pls_rx_ovs = pls_rx_ovs_q;
  assign pls_rx_mid = pls_rx_mid_q;
  assign pls_rx_bit = pls_rx_bit_q;

endmodule

// File: tb/tb_uart_bdgen_frac.sv
// Bench for uart_bdgen_frac: TX period table plus hand-written RX, reload and reset sequences.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// Build with or without +define+UART_BDGEN_FRAC_EN; expected dither intervals follow the macro.
module tb_uart_bdgen_frac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_en = 1'b0, rx_en = 1'b0, rx_sync = 1'b0, cfg_ld = 1'b0;
  logic [15:0] cfg_tx_div = '0, cfg_rx_div = '0;
  logic [3:0]  cfg_tx_frac = '0;
  logic [4:0]  cfg_rx_ovs = '0;
  logic        cfg_pend, pls_tx, pls_rx_ovs, pls_rx_mid, pls_rx_bit;

  int n_cmp = 0;
  int n_bad = 0;

  uart_bdgen_frac dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .rx_en(rx_en), .rx_sync(rx_sync),
    .cfg_ld(cfg_ld), .cfg_tx_div(cfg_tx_div), .cfg_tx_frac(cfg_tx_frac),
    .cfg_rx_div(cfg_rx_div), .cfg_rx_ovs(cfg_rx_ovs), .cfg_pend(cfg_pend),
    .pls_tx(pls_tx), .pls_rx_ovs(pls_rx_ovs), .pls_rx_mid(pls_rx_mid),
    .pls_rx_bit(pls_rx_bit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] div;
    logic [3:0]  frac;
    int          iv0, iv1, iv2, iv3, iv4;
  } tx_vec_t;

  tx_vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_tx(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pls_tx && n < 200);
  endtask

  task automatic load_cfg(input int txd, input int frac, input int rxd, input int ovs);
    tx_en = 1'b0;
    rx_en = 1'b0;
    cfg_tx_div  = 16'(txd);
    cfg_tx_frac = 4'(frac);
    cfg_rx_div  = 16'(rxd);
    cfg_rx_ovs  = 5'(ovs);
    cfg_ld = 1'b1;
    step();
    cfg_ld = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int t;
    bit e_ovs, e_mid, e_bit;

    vecs[0] = '{div:16'd10, frac:4'd0,  iv0:10, iv1:10, iv2:10, iv3:10, iv4:10};
`ifdef UART_BDGEN_FRAC_EN
    vecs[1] = '{div:16'd10, frac:4'd8,  iv0:10, iv1:10, iv2:11, iv3:10, iv4:11};
    vecs[2] = '{div:16'd3,  frac:4'd4,  iv0:3,  iv1:3,  iv2:3,  iv3:3,  iv4:4};
    vecs[4] = '{div:16'd1,  frac:4'd15, iv0:2,  iv1:2,  iv2:3,  iv3:3,  iv4:3};
`else
    vecs[1] = '{div:16'd10, frac:4'd8,  iv0:10, iv1:10, iv2:10, iv3:10, iv4:10};
    vecs[2] = '{div:16'd3,  frac:4'd4,  iv0:3,  iv1:3,  iv2:3,  iv3:3,  iv4:3};
    vecs[4] = '{div:16'd1,  frac:4'd15, iv0:2,  iv1:2,  iv2:2,  iv3:2,  iv4:2};
`endif
    vecs[3] = '{div:16'd0,  frac:4'd0,  iv0:2,  iv1:2,  iv2:2,  iv3:2,  iv4:2};

    // reset with enables high: every output held at 0
    tx_en = 1'b1;
    rx_en = 1'b1;
    step();
    step();
    chk("rst_pls_tx", int'(pls_tx), 0);
    chk("rst_pls_rx_ovs", int'(pls_rx_ovs), 0);
    chk("rst_pls_rx_mid", int'(pls_rx_mid), 0);
    chk("rst_pls_rx_bit", int'(pls_rx_bit), 0);
    chk("rst_cfg_pend", int'(cfg_pend), 0);
    rst = 1'b0;

    // TX period table
    foreach (vecs[i]) begin
      load_cfg(int'(vecs[i].div), int'(vecs[i].frac), 4, 16);
      chk($sformatf("tx%0d_pend_clr", i), int'(cfg_pend), 0);
      tx_en = 1'b1;
      wait_tx(n); chk($sformatf("tx%0d_iv0", i), n, vecs[i].iv0);
      wait_tx(n); chk($sformatf("tx%0d_iv1", i), n, vecs[i].iv1);
      wait_tx(n); chk($sformatf("tx%0d_iv2", i), n, vecs[i].iv2);
      wait_tx(n); chk($sformatf("tx%0d_iv3", i), n, vecs[i].iv3);
      wait_tx(n); chk($sformatf("tx%0d_iv4", i), n, vecs[i].iv4);
    end
    // tx_en low on the cycle after a pulse: pulse and counter drop
    tx_en = 1'b0;
    step();
    chk("tx_dis_pls", int'(pls_tx), 0);

    // RX: div 4, ovs 16 after rx_sync
    load_cfg(10, 0, 4, 16);
    rx_en = 1'b1;
    rx_sync = 1'b1;
    step();
    chk("rx_sync_no_pls", int'(pls_rx_ovs), 0);
    rx_sync = 1'b0;
    for (int s = 1; s <= 130; s++) begin
      step();
      t = s / 4;
      e_ovs = (s % 4 == 0);
      e_mid = e_ovs && ((t - 1) % 16 == 8);
      e_bit = e_ovs && (t % 16 == 0);
      if (pls_rx_ovs != e_ovs) chk($sformatf("rx_ovs_s%0d", s), int'(pls_rx_ovs), int'(e_ovs));
      if (pls_rx_mid != e_mid) chk($sformatf("rx_mid_s%0d", s), int'(pls_rx_mid), int'(e_mid));
      if (pls_rx_bit != e_bit) chk($sformatf("rx_bit_s%0d", s), int'(pls_rx_bit), int'(e_bit));
      if (s == 36) chk("rx_mid_tick9", int'(pls_rx_mid), 1);
      if (s == 64) chk("rx_bit_tick16", int'(pls_rx_bit), 1);
      if (s == 128) chk("rx_bit_tick32", int'(pls_rx_bit), 1);
      if (s == 129) chk("rx_ovs_gap", int'(pls_rx_ovs), 0);
    end

    // rx_sync on the cycle the counter would wrap
    step();
    rx_sync = 1'b1;
    step();
    chk("rx_sync_wrap_ovs", int'(pls_rx_ovs), 0);
    rx_sync = 1'b0;
    step(); chk("rx_after_sync_1", int'(pls_rx_ovs), 0);
    step(); chk("rx_after_sync_2", int'(pls_rx_ovs), 0);
    step(); chk("rx_after_sync_3", int'(pls_rx_ovs), 0);
    step(); chk("rx_after_sync_4", int'(pls_rx_ovs), 1);

    // clamps: rx_div 0 -> 1, rx_ovs 1 -> 2
    load_cfg(0, 0, 0, 1);
    chk("clamp_pend_clr", int'(cfg_pend), 0);
    rx_en = 1'b1;
    rx_sync = 1'b1;
    step();
    rx_sync = 1'b0;
    for (int s = 1; s <= 8; s++) begin
      step();
      chk($sformatf("clamp_ovs_s%0d", s), int'(pls_rx_ovs), 1);
      chk($sformatf("clamp_mid_s%0d", s), int'(pls_rx_mid), int'(s % 2 == 0));
      chk($sformatf("clamp_bit_s%0d", s), int'(pls_rx_bit), int'(s % 2 == 0));
    end
    rx_en = 1'b0;
    step();
    chk("rx_dis_ovs", int'(pls_rx_ovs), 0);
    chk("rx_dis_bit", int'(pls_rx_bit), 0);

    // mid-period reload of tx_div: current period kept, next one uses 20
    load_cfg(10, 0, 4, 16);
    tx_en = 1'b1;
    rx_en = 1'b1;
    rx_sync = 1'b1;
    step();
    rx_sync = 1'b0;
    step(); step(); step();
    cfg_tx_div = 16'd20;
    cfg_ld = 1'b1;
    step();
    cfg_ld = 1'b0;
    chk("reload_pend_set", int'(cfg_pend), 1);
    wait_tx(n); chk("reload_cur_period", n, 5);
    chk("reload_pend_rx_wait", int'(cfg_pend), 1);
    wait_tx(n); chk("reload_new_period", n, 20);
    chk("reload_pend_still", int'(cfg_pend), 1);
    rx_sync = 1'b1;
    step();
    rx_sync = 1'b0;
    chk("reload_pend_clr", int'(cfg_pend), 0);

    // reset mid-period with a pending load
    cfg_ld = 1'b1;
    step();
    cfg_ld = 1'b0;
    chk("midrst_pend_set", int'(cfg_pend), 1);
    rst = 1'b1;
    step();
    chk("midrst_pend", int'(cfg_pend), 0);
    chk("midrst_pls_tx", int'(pls_tx), 0);
    chk("midrst_pls_rx_ovs", int'(pls_rx_ovs), 0);
    rst = 1'b0;
    tx_en = 1'b0;
    rx_en = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
